// File: rtl/exe_divider_pkg.sv
// rtl/exe_divider_pkg.sv - shared types, encodings and helpers for the execute-stage divider
package exe_divider_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    // Iteration counter start value: one quotient bit per ITER cycle.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(XLEN - 1);

    // RV32M operation encodings carried on div_op_i.
    localparam logic [1:0] DIV_OP_DIV  = 2'd0;
    localparam logic [1:0] DIV_OP_DIVU = 2'd1;
    localparam logic [1:0] DIV_OP_REM  = 2'd2;
    localparam logic [1:0] DIV_OP_REMU = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // DIV and REM treat their operands as two's complement.
    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

    // Two's complement negation when neg is set, pass-through otherwise.
    function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] value,
                                                   input logic            neg);
        return neg ? ({XLEN{1'b0}} - value) : value;
    endfunction

endpackage

// File: rtl/exe_divider_if.sv
// rtl/exe_divider_if.sv - request/response bundle between the pipeline and the divider
interface exe_divider_if;
    import exe_divider_pkg::*;

    logic            div_start_i;
    logic [1:0]      div_op_i;
    logic [XLEN-1:0] div_opa_i;
    logic [XLEN-1:0] div_opb_i;
    logic            div_flush_i;
    logic            div_busy_o;
    logic            div_valid_o;
    logic [XLEN-1:0] div_result_o;

    // Pipeline side: issues requests and flushes, observes busy/result.
    modport master (
        output div_start_i,
        output div_op_i,
        output div_opa_i,
        output div_opb_i,
        output div_flush_i,
        input  div_busy_o,
        input  div_valid_o,
        input  div_result_o
    );

    // Divider side.
    modport slave (
        input  div_start_i,
        input  div_op_i,
        input  div_opa_i,
        input  div_opb_i,
        input  div_flush_i,
        output div_busy_o,
        output div_valid_o,
        output div_result_o
    );

endinterface

// File: rtl/exe_divider_div_step.sv
// rtl/exe_divider_div_step.sv - one combinational restoring shift-subtract iteration
module exe_divider_div_step
    import exe_divider_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_trial;
    logic          w_fits;

    // Shift the next dividend bit into the partial remainder. Because the
    // partial remainder is always below the divisor, the 33-bit difference
    // is exact and its top bit is a true sign bit.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign w_fits  = ~w_trial[XLEN];

    // Keep the difference when the divisor fits, otherwise restore.
    assign o_rem = w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/exe_divider.sv
// rtl/exe_divider.sv - iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle
module exe_divider
    import exe_divider_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    exe_divider_if.slave div_if
);

    div_state_e       r_state;
    logic             r_busy;
    logic             r_valid;
    logic [XLEN-1:0]  r_result;

    logic [XLEN-1:0]  r_opa;       // original dividend, returned as-is for x % 0
    logic [XLEN-1:0]  r_dividend;  // |opa| for signed ops
    logic [XLEN-1:0]  r_divisor;   // |opb| for signed ops
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [CNT_W-1:0] r_count;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_signed;
    logic [XLEN-1:0]  w_opa_abs;
    logic [XLEN-1:0]  w_opb_abs;
    logic [XLEN-1:0]  w_rem_next;
    logic [XLEN-1:0]  w_quo_next;
    logic [XLEN-1:0]  w_final;

    assign w_signed  = is_signed_op(div_if.div_op_i);
    assign w_opa_abs = cond_negate(div_if.div_opa_i, w_signed & div_if.div_opa_i[XLEN-1]);
    assign w_opb_abs = cond_negate(div_if.div_opb_i, w_signed & div_if.div_opb_i[XLEN-1]);

    exe_divider_div_step u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    // Sign fixup applied to the outcome of the final iteration. The overflow
    // case 0x8000_0000 / -1 falls out naturally: |a| = 0x8000_0000, both signs
    // set so no negation, remainder 0.
    assign w_final = r_is_rem ? cond_negate(w_rem_next, r_neg_r)
                              : cond_negate(w_quo_next, r_neg_q);

    // Control FSM plus datapath registers; busy/valid/result are registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_opa      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_count    <= '0;
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else if (div_if.div_flush_i) begin
            // Abort wins over a same-cycle start; result keeps its last value.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (div_if.div_start_i) begin
                        r_opa      <= div_if.div_opa_i;
                        r_dividend <= w_opa_abs;
                        r_divisor  <= w_opb_abs;
                        r_is_rem   <= is_rem_op(div_if.div_op_i);
                        r_neg_q    <= w_signed & (div_if.div_opa_i[XLEN-1] ^ div_if.div_opb_i[XLEN-1]);
                        r_neg_r    <= w_signed & div_if.div_opa_i[XLEN-1];
                        r_state    <= PREP;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                PREP: begin
                    if (r_divisor == '0) begin
                        // RISC-V divide-by-zero: all-ones quotient, dividend as
                        // remainder, neither sign-corrected.
                        r_result <= r_is_rem ? r_opa : {XLEN{1'b1}};
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= DONE;
                    end else begin
                        r_quo   <= r_dividend;
                        r_rem   <= '0;
                        r_count <= LAST_COUNT;
                        r_state <= ITER;
                    end
                end

                ITER: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (r_count == '0) begin
                        r_result <= w_final;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign div_if.div_busy_o   = r_busy;
    assign div_if.div_valid_o  = r_valid;
    assign div_if.div_result_o = r_result;

endmodule

// File: tb/tb_exe_divider.sv
// tb/tb_exe_divider.sv - self-checking bench for exe_divider
module tb_exe_divider;
    import exe_divider_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          at_edge;
        string       name;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    vec_t tbl[$];
    sb_t  sbq[$];

    exe_divider_if dif();

    exe_divider u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .div_if (dif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dif.div_valid_o === 1'b1) begin
            sb_t e;
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 result=%08h at edge %0d, required no valid", dif.div_result_o, cyc);
            end else begin
                e = sbq.pop_front();
                if (dif.div_result_o !== e.res || cyc != e.at_edge) begin
                    n_err++;
                    $display("FAIL %s: got %08h at edge %0d, required %08h at edge %0d",
                             e.name, dif.div_result_o, cyc, e.res, e.at_edge);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h required %08h", nm, got, exp);
        end
    endtask

    // Assumes the caller is positioned away from a clock edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int e);
        dif.div_op_i    = op;
        dif.div_opa_i   = a;
        dif.div_opb_i   = b;
        dif.div_start_i = 1'b1;
        @(posedge clk);
        #1;
        dif.div_start_i = 1'b0;
        e = cyc;
    endtask

    task automatic push_exp(input logic [31:0] res, input int e, input logic [31:0] b, input string nm);
        sb_t s;
        s.res     = res;
        s.at_edge = e + ((b == 32'd0) ? 1 : 33);
        s.name    = nm;
        sbq.push_back(s);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int e;
        @(negedge clk);
        start_op(op, a, b, e);
        push_exp(exp, e, b, nm);
        chk({nm, "_busy"}, {31'd0, dif.div_busy_o}, 32'd1);
    endtask

    task automatic goto_edge(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string nm);
        int i = 0;
        while ((sbq.size() != 0 || dif.div_busy_o !== 1'b0) && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending results, required 0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [31:0] ra, rb, rexp;
        logic [1:0]  rop;

        tbl.push_back('{op: DIV_OP_DIVU, a: 32'd100,        b: 32'd7,          exp: 32'd14,         name: "divu_100_7"});
        tbl.push_back('{op: DIV_OP_REMU, a: 32'd100,        b: 32'd7,          exp: 32'd2,          name: "remu_100_7"});
        tbl.push_back('{op: DIV_OP_DIV,  a: 32'hFFFF_FFF9,  b: 32'd2,          exp: 32'hFFFF_FFFD,  name: "div_m7_2"});
        tbl.push_back('{op: DIV_OP_REM,  a: 32'hFFFF_FFF9,  b: 32'd2,          exp: 32'hFFFF_FFFF,  name: "rem_m7_2"});
        tbl.push_back('{op: DIV_OP_REM,  a: 32'd7,          b: 32'hFFFF_FFFE,  exp: 32'd1,          name: "rem_7_m2"});
        tbl.push_back('{op: DIV_OP_DIV,  a: 32'd7,          b: 32'hFFFF_FFFE,  exp: 32'hFFFF_FFFD,  name: "div_7_m2"});
        tbl.push_back('{op: DIV_OP_DIV,  a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  exp: 32'h8000_0000,  name: "div_ovf"});
        tbl.push_back('{op: DIV_OP_REM,  a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  exp: 32'd0,          name: "rem_ovf"});
        tbl.push_back('{op: DIV_OP_DIVU, a: 32'h0000_1234,  b: 32'd0,          exp: 32'hFFFF_FFFF,  name: "divu_by0"});
        tbl.push_back('{op: DIV_OP_REM,  a: 32'hFFFF_FFFB,  b: 32'd0,          exp: 32'hFFFF_FFFB,  name: "rem_m5_by0"});
        tbl.push_back('{op: DIV_OP_DIV,  a: 32'hFFFF_FFFB,  b: 32'd0,          exp: 32'hFFFF_FFFF,  name: "div_m5_by0"});
        tbl.push_back('{op: DIV_OP_REMU, a: 32'h0000_1234,  b: 32'd0,          exp: 32'h0000_1234,  name: "remu_by0"});
        tbl.push_back('{op: DIV_OP_DIV,  a: 32'hFFFF_FF9C,  b: 32'hFFFF_FFF9,  exp: 32'd14,         name: "div_m100_m7"});
        tbl.push_back('{op: DIV_OP_REM,  a: 32'hFFFF_FF9C,  b: 32'hFFFF_FFF9,  exp: 32'hFFFF_FFFE,  name: "rem_m100_m7"});
        tbl.push_back('{op: DIV_OP_DIVU, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp: 32'd1,          name: "divu_max_max"});
        tbl.push_back('{op: DIV_OP_REMU, a: 32'hFFFF_FFFF,  b: 32'd1,          exp: 32'd0,          name: "remu_max_1"});
        tbl.push_back('{op: DIV_OP_DIVU, a: 32'd5,          b: 32'd10,         exp: 32'd0,          name: "divu_5_10"});
        tbl.push_back('{op: DIV_OP_REMU, a: 32'd5,          b: 32'd10,         exp: 32'd5,          name: "remu_5_10"});
        tbl.push_back('{op: DIV_OP_DIVU, a: 32'hFFFF_FFFF,  b: 32'd2,          exp: 32'h7FFF_FFFF,  name: "divu_max_2"});
        tbl.push_back('{op: DIV_OP_DIV,  a: 32'hFFFF_FFFF,  b: 32'd2,          exp: 32'd0,          name: "div_m1_2"});
        tbl.push_back('{op: DIV_OP_REM,  a: 32'hFFFF_FFFF,  b: 32'd2,          exp: 32'hFFFF_FFFF,  name: "rem_m1_2"});

        for (int i = 0; i < 8; i++) begin
            ra   = $urandom;
            rb   = $urandom >> (i * 4);
            rop  = (i % 2 == 0) ? DIV_OP_DIVU : DIV_OP_REMU;
            if (rb == 32'd0)
                rexp = (rop == DIV_OP_REMU) ? ra : 32'hFFFF_FFFF;
            else
                rexp = (rop == DIV_OP_REMU) ? (ra % rb) : (ra / rb);
            tbl.push_back('{op: rop, a: ra, b: rb, exp: rexp, name: $sformatf("rand_%0d", i)});
        end

        dif.div_start_i = 1'b0;
        dif.div_op_i    = 2'd0;
        dif.div_opa_i   = '0;
        dif.div_opb_i   = '0;
        dif.div_flush_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy",   {31'd0, dif.div_busy_o},  32'd0);
        chk("reset_valid",  {31'd0, dif.div_valid_o}, 32'd0);
        chk("reset_result", dif.div_result_o,         32'd0);

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);
            drain(tbl[i].name);
        end

        // Ignored start mid-operation, then a flush: no result may appear.
        @(negedge clk);
        start_op(DIV_OP_DIVU, 32'd100, 32'd7, e);
        goto_edge(e + 9);
        dif.div_op_i    = DIV_OP_DIVU;
        dif.div_opa_i   = 32'd55;
        dif.div_opb_i   = 32'd1;
        dif.div_start_i = 1'b1;
        goto_edge(e + 10);
        dif.div_start_i = 1'b0;
        chk("ignored_start_busy", {31'd0, dif.div_busy_o}, 32'd1);
        goto_edge(e + 19);
        dif.div_flush_i = 1'b1;
        goto_edge(e + 20);
        dif.div_flush_i = 1'b0;
        chk("flush_busy",  {31'd0, dif.div_busy_o},  32'd0);
        chk("flush_valid", {31'd0, dif.div_valid_o}, 32'd0);
        goto_edge(e + 50);
        run_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, "after_flush");
        drain("after_flush");

        // Reset mid-operation clears busy and the held result.
        @(negedge clk);
        start_op(DIV_OP_REMU, 32'd100, 32'd7, e);
        goto_edge(e + 4);
        rst = 1'b1;
        goto_edge(e + 5);
        rst = 1'b0;
        chk("midrst_busy",   {31'd0, dif.div_busy_o},  32'd0);
        chk("midrst_valid",  {31'd0, dif.div_valid_o}, 32'd0);
        chk("midrst_result", dif.div_result_o,         32'd0);
        goto_edge(e + 45);

        // Start issued in the DONE cycle: next valid exactly 34 cycles later.
        run_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, "b2b_first");
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (dif.div_valid_o !== 1'b1 && k < 60);
        end
        start_op(DIV_OP_REMU, 32'd100, 32'd7, e);
        push_exp(32'd2, e, 32'd7, "b2b_second");
        chk("b2b_busy", {31'd0, dif.div_busy_o}, 32'd1);
        drain("b2b");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exe_divider.md
# exe_divider

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the execute stage beside the combinational adder. It accepts one operation through a start pulse and computes the result by restoring shift-subtract, one quotient bit per cycle. It returns the result with a one-cycle valid pulse, so the pipeline stalls on `div_busy_o` while the operation runs.

## Interface
Parameters:
- none (width fixed at 32, per RV32)

Ports:
- `clk_i` in 1 — core clock, all state on rising edge
- `rst_i` in 1 — synchronous, active-high reset
- `div_start_i` in 1 — request; sampled only when not busy
- `div_op_i` in 2 — operation: 0 DIV, 1 DIVU, 2 REM, 3 REMU
- `div_opa_i` in 32 — dividend (rs1 value)
- `div_opb_i` in 32 — divisor (rs2 value)
- `div_flush_i` in 1 — abort in-flight operation (pipeline flush)
- `div_busy_o` out 1 — high in PREP and ITER
- `div_valid_o` out 1 — one-cycle pulse, result valid
- `div_result_o` out 32 — quotient or remainder; holds last value until next DONE

## Operation
- States: IDLE, PREP, ITER, DONE.
- IDLE/DONE + `div_start_i`: latch op, capture |opa| and |opb| (signed ops only), record quotient-negate = sign(opa)^sign(opb), remainder-negate = sign(opa) → PREP.
- PREP: if divisor == 0 → DONE with quotient 32'hFFFF_FFFF, remainder = original opa (no sign fix). Else load quotient register = |opa|, partial remainder = 0, count = 31 → ITER.
- ITER, each cycle: {rem,quo} shifted left 1; trial = rem_shifted − divisor (33-bit); if trial non-negative, rem = trial and quotient LSB = 1, else restore and LSB = 0. At count == 0 → DONE; otherwise count−1.
- DONE: `div_result_o` = (DIV/DIVU ? quotient : remainder), negated per the recorded sign flags for signed ops; `div_valid_o` = 1 → IDLE, or PREP if `div_start_i`.
- Signed overflow (0x8000_0000 / −1) needs no special path: it yields quotient 0x8000_0000 and remainder 0, as RISC-V requires.
- `div_start_i` in PREP/ITER is ignored (no queueing).
- `div_flush_i` in any state → IDLE next cycle, no valid pulse; flush has priority over start in the same cycle.
- `rst_i` behaves like flush, and additionally clears `div_result_o`.

## Timing
- Reset values: `div_busy_o` 0, `div_valid_o` 0, `div_result_o` 0, state IDLE.
- Start sampled at edge T: PREP at T+1, ITER T+2..T+33, `div_valid_o` high in cycle T+34 (latency 34).
- Divide-by-zero: `div_valid_o` at T+2.
- Back-to-back: a start in the DONE cycle gives the next valid 34 cycles later; maximum throughput is one op per 34 cycles.
- `div_result_o` is registered; there is no combinational path from inputs to outputs.

## Structure
- The shared core package holds:
  - `DIV_OP_*` encodings (2-bit)
  - the `div_state_e` enum {IDLE, PREP, ITER, DONE}
  - `XLEN = 32`
- The sub-module `div_step` is purely combinational: it takes rem, quo and divisor, and produces the next rem and quo for one restoring iteration.
- `exe_divider` instantiates one `div_step` and owns the FSM, counter and sign fixup.

## Test plan
- DIVU 100/7 → `div_result_o` = 14 with `div_valid_o` exactly at T+34; REMU same operands → 2.
- DIV −7/2 → 0xFFFF_FFFD (−3); REM −7/2 → 0xFFFF_FFFF (−1); REM 7/−2 → 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM same operands → 0.
- DIVU 0x1234/0 → 0xFFFF_FFFF at T+2; REM −5/0 → 0xFFFF_FFFB.
- Start DIVU 100/7, pulse start with other operands at T+10 (ignored), flush at T+20 → no valid pulse, busy low at T+21; a new start afterwards completes correctly.
- Start then assert `rst_i` at T+5 → busy 0, result 0, no valid; a start in the DONE cycle gives the second valid at exactly +34.
